// File: rtl/uart_core_if.sv
// ---------------------------------------------------------------------------
// uart_core_if
//
// Purpose : groups the two byte-wide handshake channels of uart_core.
//           The TX channel carries bytes into the transmitter; the RX channel
//           is the read side of the receive FIFO.
//
// Signals (names are written from the core's point of view):
//   tx_data_i  [DATA_BITS] byte to transmit
//   tx_valid_i             tx_data_i is valid
//   tx_ready_o             transmitter idle, can accept a byte
//   rx_data_o  [DATA_BITS] head entry of the RX FIFO (first-word-fall-through)
//   rx_valid_o             RX FIFO not empty
//   rx_ready_i             consumer takes the head entry this cycle
//
// Modports:
//   slave  - the UART core
//   master - the user logic that feeds TX and drains RX
// ---------------------------------------------------------------------------
interface uart_core_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data_i;
    logic                 tx_valid_i;
    logic                 tx_ready_o;
    logic [DATA_BITS-1:0] rx_data_o;
    logic                 rx_valid_o;
    logic                 rx_ready_i;

    modport master (
        output tx_data_i, tx_valid_i, rx_ready_i,
        input  tx_ready_o, rx_data_o, rx_valid_o
    );

    modport slave (
        input  tx_data_i, tx_valid_i, rx_ready_i,
        output tx_ready_o, rx_data_o, rx_valid_o
    );
endinterface

// File: rtl/uart_core.sv
// ---------------------------------------------------------------------------
// uart_core
//
// Purpose : UART transmitter and receiver with a first-word-fall-through
//           receive FIFO. TX and RX run from independent counters.
//           Frame: 1 start bit (0), DATA_BITS data bits LSB first, optional
//           parity bit, STOP_BITS stop bits (1). Only the first stop bit is
//           checked on receive.
//
// Configuration macro:
//   UART_PARITY_EN - when defined, a parity bit follows the data bits on both
//                    TX and RX, polarity from parity_odd_i. When undefined the
//                    parity state does not exist, parity_odd_i is ignored and
//                    parity_err_o is tied to 0.
//
// Parameters:
//   CLK_DIV    clock cycles per bit (>= 4)
//   DATA_BITS  data bits per frame (5..8)
//   STOP_BITS  stop bits per transmitted frame (1 or 2)
//   FIFO_DEPTH RX FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk_i        the only clock
//   rst_i        asynchronous active-high reset
//   rx_i         serial input, asynchronous to clk_i
//   tx_o         serial output, idle high
//   rx_en_i      receiver enable; low aborts any frame in progress
//   parity_odd_i 1 = odd parity, 0 = even parity
//   bus          TX valid/ready channel and RX FIFO read channel (slave)
//   rx_level_o   RX FIFO occupancy, 0..FIFO_DEPTH
//   frame_err_o  single-cycle pulse: received stop bit was 0
//   parity_err_o single-cycle pulse: received parity bit wrong
//   overflow_o   single-cycle pulse: good byte dropped because FIFO full
// ---------------------------------------------------------------------------
module uart_core #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rx_i,
    output logic                          tx_o,
    input  logic                          rx_en_i,
    input  logic                          parity_odd_i,
    uart_core_if.slave                    bus,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level_o,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          overflow_o
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_e;

    // -----------------------------------------------------------------------
    // RX input synchronizer and falling-edge detector
    // -----------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;
    logic w_rx_fall;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like hardware.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // -----------------------------------------------------------------------
    // RX FSM
    // -----------------------------------------------------------------------
    state_e                 r_rx_state;
    state_e                 w_rx_state_nxt;
    logic [CNT_W-1:0]       r_rx_cnt;
    logic [2:0]             r_rx_bit;
    logic [DATA_BITS-1:0]   r_rx_shift;
    logic                   r_rx_done;
    logic                   r_rx_stop_ok;
    logic                   w_rx_tick;
    logic                   w_rx_par_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_rx_state <= ST_IDLE;
        else       r_rx_state <= w_rx_state_nxt;
    end

    // NOTE: every output of a combinational block gets a value before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        // START waits half a bit to land mid-bit; later bits are a full bit apart.
        w_rx_tick      = (r_rx_cnt == ((r_rx_state == ST_START) ? HALF_LAST : DIV_LAST));
        w_rx_state_nxt = r_rx_state;
        case (r_rx_state)
            ST_IDLE:   if (w_rx_fall) w_rx_state_nxt = ST_START;
            ST_START:  if (w_rx_tick) w_rx_state_nxt = r_rx_sync ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (w_rx_tick && (r_rx_bit == DATA_LAST)) begin
`ifdef UART_PARITY_EN
                    w_rx_state_nxt = ST_PARITY;
`else
                    w_rx_state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: if (w_rx_tick) w_rx_state_nxt = ST_STOP;
`endif
            ST_STOP:   if (w_rx_tick) w_rx_state_nxt = ST_IDLE;
            default:   w_rx_state_nxt = ST_IDLE;
        endcase
        if (!rx_en_i) w_rx_state_nxt = ST_IDLE;
    end

`ifdef UART_PARITY_EN
    logic r_rx_par_ok;
    assign w_rx_par_ok = r_rx_par_ok;
`else
    assign w_rx_par_ok = 1'b1;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_done    <= 1'b0;
            r_rx_stop_ok <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_par_ok  <= 1'b0;
`endif
        end else begin
            r_rx_done <= 1'b0;
            if ((r_rx_state == ST_IDLE) || w_rx_tick) r_rx_cnt <= '0;
            else                                      r_rx_cnt <= r_rx_cnt + 1'b1;
            if (r_rx_state == ST_START) r_rx_bit <= '0;
            // Sampling is gated by rx_en_i so an aborted frame leaves no trace.
            if (rx_en_i && w_rx_tick) begin
                case (r_rx_state)
                    ST_DATA: begin
                        r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                    end
`ifdef UART_PARITY_EN
                    ST_PARITY: r_rx_par_ok <= (r_rx_sync == (^r_rx_shift ^ parity_odd_i));
`endif
                    ST_STOP: begin
                        r_rx_stop_ok <= r_rx_sync;
                        r_rx_done    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // RX FIFO (first-word-fall-through)
    // -----------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic                 w_good;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;

    assign w_good = r_rx_done & r_rx_stop_ok & w_rx_par_ok;
    assign w_full = (r_level == LVL_FULL);
    assign w_pop  = (r_level != '0) & bus.rx_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = w_good & (~w_full | w_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

    // NOTE: the storage array has no reset; r_level decides what is valid,
    // and the read data is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= r_rx_shift;
    end

    assign bus.rx_valid_o = (r_level != '0);
    assign bus.rx_data_o  = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
    assign rx_level_o     = r_level;

    assign frame_err_o = r_rx_done & ~r_rx_stop_ok;
    assign overflow_o  = w_good & w_full & ~w_pop;
`ifdef UART_PARITY_EN
    assign parity_err_o = r_rx_done & ~r_rx_par_ok;
`else
    assign parity_err_o = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // TX FSM
    // -----------------------------------------------------------------------
    state_e               r_tx_state;
    state_e               w_tx_state_nxt;
    logic [CNT_W-1:0]     r_tx_cnt;
    logic [2:0]           r_tx_bit;
    logic                 r_tx_stop;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_out;
    logic                 r_tx_live;
    logic                 w_tx_tick;
    logic                 w_tx_ready;
    logic                 w_tx_fire;

    // r_tx_live keeps tx_ready_o low while reset is asserted.
    assign w_tx_ready = (r_tx_state == ST_IDLE) & r_tx_live;
    assign w_tx_fire  = bus.tx_valid_i & w_tx_ready;
    assign w_tx_tick  = (r_tx_cnt == DIV_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_tx_state <= ST_IDLE;
        else       r_tx_state <= w_tx_state_nxt;
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            ST_IDLE:  if (w_tx_fire) w_tx_state_nxt = ST_START;
            ST_START: if (w_tx_tick) w_tx_state_nxt = ST_DATA;
            ST_DATA: begin
                if (w_tx_tick && (r_tx_bit == DATA_LAST)) begin
`ifdef UART_PARITY_EN
                    w_tx_state_nxt = ST_PARITY;
`else
                    w_tx_state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: if (w_tx_tick) w_tx_state_nxt = ST_STOP;
`endif
            ST_STOP:  if (w_tx_tick && (r_tx_stop == STOP_LAST)) w_tx_state_nxt = ST_IDLE;
            default:  w_tx_state_nxt = ST_IDLE;
        endcase
    end

`ifdef UART_PARITY_EN
    logic r_tx_par;
`else
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = parity_odd_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_stop  <= 1'b0;
            r_tx_shift <= '0;
            r_tx_out   <= 1'b1;
            r_tx_live  <= 1'b0;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            r_tx_live <= 1'b1;
            if ((r_tx_state == ST_IDLE) || w_tx_tick) r_tx_cnt <= '0;
            else                                      r_tx_cnt <= r_tx_cnt + 1'b1;
            case (r_tx_state)
                ST_IDLE: begin
                    if (w_tx_fire) begin
                        r_tx_shift <= bus.tx_data_i;
                        r_tx_out   <= 1'b0;
                        r_tx_bit   <= '0;
                        r_tx_stop  <= 1'b0;
`ifdef UART_PARITY_EN
                        r_tx_par   <= ^bus.tx_data_i ^ parity_odd_i;
`endif
                    end
                end
                ST_START: begin
                    if (w_tx_tick) begin
                        r_tx_out   <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
                    end
                end
                ST_DATA: begin
                    if (w_tx_tick) begin
                        r_tx_bit <= r_tx_bit + 3'd1;
                        if (r_tx_bit == DATA_LAST) begin
`ifdef UART_PARITY_EN
                            r_tx_out <= r_tx_par;
`else
                            r_tx_out <= 1'b1;
`endif
                        end else begin
                            r_tx_out   <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
                        end
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: if (w_tx_tick) r_tx_out <= 1'b1;
`endif
                ST_STOP: if (w_tx_tick) r_tx_stop <= r_tx_stop + 1'b1;
                default: ;
            endcase
        end
    end

    assign tx_o           = r_tx_out;
    assign bus.tx_ready_o = w_tx_ready;

endmodule

// File: tb/tb_uart_core.sv
// ---------------------------------------------------------------------------
// tb_uart_core
//
// Purpose : self-checking bench for uart_core with CLK_DIV=4, DATA_BITS=8,
//           STOP_BITS=1, FIFO_DEPTH=4. Covers reset values, TX bit timing,
//           loopback, a table of directly driven RX frames (good, frame
//           error, and parity cases when UART_PARITY_EN is defined), false
//           start, receiver disable, FIFO overflow and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_uart_core;

    localparam int CLK_DIV    = 4;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FIFO_DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int P_BITS = 1;
`else
    localparam int P_BITS = 0;
`endif
    localparam int FRAME_BITS = 1 + DATA_BITS + P_BITS + STOP_BITS;
    localparam int FRAME_CYC  = FRAME_BITS * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       rx_line;
    logic       tx_line;
    logic [2:0] level;
    logic       fe;
    logic       pe;
    logic       ov;

    uart_core_if #(.DATA_BITS(DATA_BITS)) bus ();

    assign rx_line = loop_en ? tx_line : rx_drv;

    uart_core #(
        .CLK_DIV   (CLK_DIV),
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (rx_line),
        .tx_o        (tx_line),
        .rx_en_i     (rx_en),
        .parity_odd_i(parity_odd),
        .bus         (bus),
        .rx_level_o  (level),
        .frame_err_o (fe),
        .parity_err_o(pe),
        .overflow_o  (ov)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_fe = 0;
    int n_pe = 0;
    int n_ov = 0;

    // Error pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (fe) n_fe <= n_fe + 1;
        if (pe) n_pe <= n_pe + 1;
        if (ov) n_ov <= n_ov + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       par;
        logic       push;
        logic       fe;
        logic       pe;
    } rx_vec_t;

    rx_vec_t    rx_vecs[6];
    int         n_rx_vecs;
    logic [7:0] tx_vecs[2];
    logic [7:0] loop_bytes[3];
    logic [7:0] ovf_bytes[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_tx_bit(input logic [7:0] d, input int idx, input logic odd);
        if (idx == 0) return 1'b0;
        if (idx <= DATA_BITS) return d[idx-1];
        if (P_BITS == 1 && idx == DATA_BITS + 1) return (^d) ^ odd;
        return 1'b1;
    endfunction

    task automatic wait_ready(input int budget);
        int i = 0;
        while (!bus.tx_ready_o && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("tx_ready_wait", bus.tx_ready_o, 1);
    endtask

    // Ends on the first negedge after the handshake edge.
    task automatic tx_start(input logic [7:0] d);
        wait_ready(4 * FRAME_CYC);
        bus.tx_data_i  = d;
        bus.tx_valid_i = 1'b1;
        @(negedge clk);
        bus.tx_valid_i = 1'b0;
    endtask

    task automatic tx_loop_byte(input logic [7:0] d);
        tx_start(d);
        repeat (FRAME_CYC + 3 * CLK_DIV) @(negedge clk);
    endtask

    task automatic rx_bit(input logic v);
        rx_drv = v;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop, input logic par);
        rx_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) rx_bit(d[i]);
        if (P_BITS == 1) rx_bit(par);
        rx_bit(stop);
        rx_drv = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check({name, "_valid"}, bus.rx_valid_o, 1);
        check(name, bus.rx_data_o, exp);
        bus.rx_ready_i = 1'b1;
        @(negedge clk);
        bus.rx_ready_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end

    initial begin
        int fe0, pe0, ov0, lows;
        logic [2:0] lvl0;

        // Vectors: data, stop bit, parity bit driven, expect push/fe/pe.
        rx_vecs[0] = '{data: 8'h3C, stop: 1'b1, par: 1'b0, push: 1'b1, fe: 1'b0, pe: 1'b0};
        rx_vecs[1] = '{data: 8'h81, stop: 1'b0, par: 1'b0, push: 1'b0, fe: 1'b1, pe: 1'b0};
        rx_vecs[2] = '{data: 8'hC5, stop: 1'b1, par: 1'b0, push: 1'b1, fe: 1'b0, pe: 1'b0};
`ifdef UART_PARITY_EN
        rx_vecs[3] = '{data: 8'h07, stop: 1'b1, par: 1'b0, push: 1'b0, fe: 1'b0, pe: 1'b1};
        rx_vecs[4] = '{data: 8'h07, stop: 1'b1, par: 1'b1, push: 1'b1, fe: 1'b0, pe: 1'b0};
        rx_vecs[5] = '{data: 8'h81, stop: 1'b0, par: 1'b1, push: 1'b0, fe: 1'b1, pe: 1'b1};
        n_rx_vecs = 6;
`else
        n_rx_vecs = 3;
`endif
        tx_vecs    = '{8'h55, 8'hA3};
        loop_bytes = '{8'h0A, 8'hFF, 8'h00};
        ovf_bytes  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        bus.tx_data_i  = '0;
        bus.tx_valid_i = 1'b0;
        bus.rx_ready_i = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx_o", tx_line, 1);
        check("rst_tx_ready", bus.tx_ready_o, 0);
        check("rst_rx_valid", bus.rx_valid_o, 0);
        check("rst_level", level, 0);
        check("rst_rx_data", bus.rx_data_o, 0);
        check("rst_err_pulses", {fe, pe, ov}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("tx_ready_after_rst", bus.tx_ready_o, 1);
        rx_en = 1'b1;

        // TX bit timing
        foreach (tx_vecs[v]) begin
            tx_start(tx_vecs[v]);
            for (int k = 0; k < FRAME_CYC; k++) begin
                check($sformatf("tx%0d_bit_k%0d", v, k), tx_line,
                      exp_tx_bit(tx_vecs[v], k / CLK_DIV, parity_odd));
                check($sformatf("tx%0d_busy_k%0d", v, k), bus.tx_ready_o, 0);
                @(negedge clk);
            end
            check($sformatf("tx%0d_ready_end", v), bus.tx_ready_o, 1);
            check($sformatf("tx%0d_idle_end", v), tx_line, 1);
        end

        // Loopback, no pops until all three bytes are in
        loop_en = 1'b1;
        fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
        foreach (loop_bytes[i]) begin
            tx_loop_byte(loop_bytes[i]);
            check($sformatf("loop_level_%0d", i), level, 3'(i + 1));
        end
        check("loop_errs", (n_fe - fe0) + (n_pe - pe0) + (n_ov - ov0), 0);
        foreach (loop_bytes[i]) pop_check($sformatf("loop_data_%0d", i), loop_bytes[i]);
        check("loop_level_empty", level, 0);
        loop_en = 1'b0;

        // Table of directly driven RX frames
        for (int i = 0; i < n_rx_vecs; i++) begin
            fe0 = n_fe; pe0 = n_pe; ov0 = n_ov; lvl0 = level;
            rx_frame(rx_vecs[i].data, rx_vecs[i].stop, rx_vecs[i].par);
            check($sformatf("rxv%0d_level", i), level, lvl0 + 3'(rx_vecs[i].push));
            check($sformatf("rxv%0d_fe", i), n_fe - fe0, 32'(rx_vecs[i].fe));
            check($sformatf("rxv%0d_pe", i), n_pe - pe0, 32'(rx_vecs[i].pe));
            check($sformatf("rxv%0d_ov", i), n_ov - ov0, 0);
            if (rx_vecs[i].push) pop_check($sformatf("rxv%0d_data", i), rx_vecs[i].data);
        end

        // False start: one-cycle low glitch
        fe0 = n_fe; pe0 = n_pe; ov0 = n_ov; lvl0 = level;
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (4 * CLK_DIV) @(negedge clk);
        check("glitch_level", level, lvl0);
        check("glitch_errs", (n_fe - fe0) + (n_pe - pe0) + (n_ov - ov0), 0);

        // Receiver disabled mid-frame: all-ones frame is aborted silently
        fe0 = n_fe; pe0 = n_pe; ov0 = n_ov; lvl0 = level;
        rx_bit(1'b0);
        rx_bit(1'b1);
        rx_en = 1'b0;
        repeat (2 * CLK_DIV) @(negedge clk);
        rx_en = 1'b1;
        repeat ((FRAME_BITS + 2) * CLK_DIV) @(negedge clk);
        check("abort_level", level, lvl0);
        check("abort_errs", (n_fe - fe0) + (n_pe - pe0) + (n_ov - ov0), 0);

        // Receiver disabled for a whole frame, then a good frame
        rx_en = 1'b0;
        rx_frame(8'h33, 1'b1, 1'b0);
        check("disabled_level", level, lvl0);
        rx_en = 1'b1;
        rx_frame(8'h5A, 1'b1, 1'b0);
        check("reenable_level", level, lvl0 + 3'd1);
        pop_check("reenable_data", 8'h5A);

        // Overflow: five bytes into a four-entry FIFO
        loop_en = 1'b1;
        fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
        foreach (ovf_bytes[i]) tx_loop_byte(ovf_bytes[i]);
        check("ovf_level", level, 4);
        check("ovf_pulses", n_ov - ov0, 1);
        check("ovf_other_errs", (n_fe - fe0) + (n_pe - pe0), 0);
        for (int i = 0; i < 4; i++) pop_check($sformatf("ovf_data_%0d", i), ovf_bytes[i]);
        check("ovf_level_empty", level, 0);
        loop_en = 1'b0;

        // Reset in the middle of a TX frame, with a byte waiting in the FIFO
        rx_frame(8'h3C, 1'b1, 1'b0);
        check("pre_rst_level", level, 1);
        tx_start(8'hA5);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx_o", tx_line, 1);
        check("midrst_tx_ready", bus.tx_ready_o, 0);
        check("midrst_level", level, 0);
        check("midrst_rx_valid", bus.rx_valid_o, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", bus.tx_ready_o, 1);
        lows = 0;
        repeat (FRAME_CYC + CLK_DIV) begin
            if (!tx_line) lows++;
            @(negedge clk);
        end
        check("midrst_no_resend", lows, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, clock cycles per bit; legal values are integers of 4 or more.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range is 5..8.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values are 1 or 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, RX FIFO entries; must be a power of 2 and at least 2.
REQ-005 SHALL have port clk_i, input, 1 bit: the only clock.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port rx_i, input, 1 bit: serial input, asynchronous to clk_i.
REQ-008 SHALL have port tx_o, output, 1 bit: serial output, idle high.
REQ-009 SHALL have port rx_en_i, input, 1 bit: receiver enable.
REQ-010 SHALL have port parity_odd_i, input, 1 bit: 1 selects odd parity, 0 selects even.
REQ-011 SHALL have ports tx_data_i (input, DATA_BITS), tx_valid_i (input, 1) and tx_ready_o (output, 1) forming the TX valid/ready channel.
REQ-012 SHALL have ports rx_data_o (output, DATA_BITS), rx_valid_o (output, 1) and rx_ready_i (input, 1) forming the RX FIFO read channel.
REQ-013 SHALL have port rx_level_o, output, $clog2(FIFO_DEPTH)+1 bits: RX FIFO occupancy.
REQ-014 SHALL have ports frame_err_o, parity_err_o and overflow_o, outputs, 1 bit each: single-cycle error pulses.

Function
REQ-015 SHALL pass rx_i through a 2-flop synchronizer, reset value 1, before any use.
REQ-016 SHALL implement the RX FSM states IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on a synchronized 1->0 transition.
REQ-017 SHALL resample the line in START CLK_DIV/2 cycles after the edge.
- Line high: false start, return to IDLE with nothing pushed.
- Line low: enter DATA.
REQ-018 SHALL sample each subsequent bit every CLK_DIV cycles, data LSB first.
REQ-019 SHALL check only the first stop bit on RX, regardless of STOP_BITS.
REQ-020 SHALL, one cycle after the stop-bit sample, push the byte into the RX FIFO only if the stop bit is 1, parity is good and the FIFO is not full.
REQ-021 SHALL pulse the matching error output in that same cycle otherwise and discard the byte.
- Stop bit 0: frame_err_o.
- Bad parity: parity_err_o.
- FIFO full: overflow_o.
- Frame and parity errors may pulse together; overflow pulses only on an otherwise-good byte.
REQ-022 SHALL be a first-word-fall-through FIFO.
- rx_valid_o = (rx_level_o != 0); rx_data_o = head entry.
- A pop occurs when rx_valid_o and rx_ready_i are both high.
REQ-023 SHALL, on a simultaneous pop and push with the FIFO full, accept the push (pop evaluated first); rx_level_o stays FIFO_DEPTH.
REQ-024 SHALL wrap pointers modulo FIFO_DEPTH; occupancy counts 0..FIFO_DEPTH.
REQ-025 SHALL, when rx_en_i is low, force the RX FSM to IDLE within 1 cycle and abort any frame in progress with no push and no error pulse; FIFO contents and the read side are unaffected.
REQ-026 SHALL implement the TX FSM states IDLE, START, DATA, PARITY, STOP.
- tx_ready_o = 1 only in IDLE.
- Handshake on tx_valid_i & tx_ready_o captures tx_data_i.
- tx_o drives 0 from the next cycle.
REQ-027 SHALL hold each TX bit exactly CLK_DIV cycles, LSB first, then STOP_BITS stop bits of 1.
- tx_ready_o reasserts in the cycle after the last stop bit ends.
REQ-028 SHALL give a TX frame length of (1+DATA_BITS+P+STOP_BITS)*CLK_DIV cycles from handshake+1, where P=1 with parity compiled in, else 0.
REQ-029 SHALL keep TX and RX fully independent, with no shared counters.

Reset
REQ-030 SHALL place both FSMs in IDLE and empty the FIFO (pointers 0) on rst_i high, asynchronously.
REQ-031 SHALL, under reset, drive tx_o=1, tx_ready_o=0, rx_valid_o=0, rx_level_o=0, rx_data_o=0 and all error pulses=0.
REQ-032 SHALL assert tx_ready_o in the first cycle after rst_i deasserts.
REQ-033 SHALL, on reset mid-frame, force tx_o high immediately and not resend the aborted byte.

Configuration
REQ-034 SHALL compile in a parity bit after the data bits on both TX and RX, polarity per parity_odd_i, when macro UART_PARITY_EN is defined.
REQ-035 SHALL, when UART_PARITY_EN is undefined, omit the PARITY state, ignore parity_odd_i and tie parity_err_o to 0.

Verification
REQ-036 SHALL cover TX timing: CLK_DIV=4, no parity, 1 stop; send 0x55 -> tx_o pattern 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; tx_ready_o low 40 cycles.
REQ-037 SHALL cover loopback: rx_i=tx_o; send 0x0A, 0xFF, 0x00 -> FIFO returns the same bytes in order; rx_level_o peaks at 3 when not popped.
REQ-038 SHALL cover a frame error: drive a frame with stop bit 0 -> frame_err_o one pulse, rx_level_o unchanged.
REQ-039 SHALL cover overflow: FIFO_DEPTH=4, send 5 bytes with no pop -> rx_level_o=4, one overflow_o pulse, first 4 bytes retained.
REQ-040 SHALL cover a false start: 1-cycle low glitch on rx_i -> no push and no error pulse.
REQ-041 SHALL cover parity with UART_PARITY_EN and even parity: 0x07 with parity bit 0 -> parity_err_o pulse, byte dropped; with parity bit 1 -> byte accepted.
